// File: rtl/swipt_pkg.sv
// Shared definitions for the SWIPT PWM generator.
//   L_WIDTH      - width of the level / counter datapath
//   PERIOD_DEF   - default PWM period in clk cycles (also full-scale level)
//   DEADTIME_DEF - default dead time in clk cycles
//   swipt_state_t - gate-drive FSM state encoding
//   clamp_level  - saturates a requested level to the full-scale value
package swipt_pkg;

  localparam int L_WIDTH      = 12;
  localparam int PERIOD_DEF   = 500;
  localparam int DEADTIME_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    H_ON = 2'd1,
    DT   = 2'd2,
    L_ON = 2'd3
  } swipt_state_t;

  function automatic logic [L_WIDTH-1:0] clamp_level(
    input logic [L_WIDTH-1:0] level,
    input logic [L_WIDTH-1:0] full
  );
    return (level > full) ? full : level;
  endfunction

endpackage

// File: rtl/swipt_deadtime.sv
// Dead-time gate-drive FSM for the SWIPT half bridge.
// Turns the raw demand (high side wanted) into two registered, never
// overlapping gate drives, inserting exactly DEADTIME cycles with both gates
// low at every high/low changeover.
// Ports:
//   clk    - clock, rising edge
//   nrst   - asynchronous active-low reset
//   en     - run enable; low forces IDLE
//   raw    - demand: 1 = high side wanted, 0 = low side wanted
//   pwm_h  - high-side gate drive (registered)
//   pwm_l  - low-side gate drive (registered)
//   state  - current FSM state (debug visibility)
module swipt_deadtime
  import swipt_pkg::*;
#(
  parameter int DEADTIME = DEADTIME_DEF
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         raw,
  output logic         pwm_h,
  output logic         pwm_l,
  output swipt_state_t state
);

  localparam logic [L_WIDTH-1:0] DT_LOAD = L_WIDTH'(DEADTIME - 1);

  swipt_state_t       next_state;
  logic [L_WIDTH-1:0] dt_cnt;

  always_comb begin
    next_state = state;
    if (!en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = DT;
        H_ON:    if (!raw) next_state = DT;
        L_ON:    if (raw)  next_state = DT;
        // Side is chosen only when dead time expires, so a demand pulse
        // shorter than DEADTIME returns to the side it left from.
        DT:      if (dt_cnt == '0) next_state = raw ? H_ON : L_ON;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      dt_cnt <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else begin
      state <= next_state;
      // Gate flops decode the next state so they coincide with the state
      // register rather than lagging it by a cycle.
      pwm_h <= (next_state == H_ON);
      pwm_l <= (next_state == L_ON);
      if (next_state == DT && state != DT) begin
        dt_cnt <= DT_LOAD;
      end else if (state == DT && dt_cnt != '0) begin
        dt_cnt <= dt_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/swipt_pwm_gen.sv
// SWIPT PWM generator top.
// A free-running period counter compares against a shadowed level to form
// the high-side demand; the dead-time FSM turns that into gate drives.
// Ports:
//   clk          - clock, rising edge
//   nrst         - asynchronous active-low reset
//   en           - run enable; low forces idle and holds the counter at 0
//   l            - requested high-side on-time in counts (0..PERIOD)
//   pwm_h        - high-side gate drive (registered)
//   pwm_l        - low-side gate drive (registered)
//   period_start - one-cycle pulse while cnt==0 and en=1
//   l_active     - level in use for the current period
//   fsm_state    - dead-time FSM state (debug visibility)
module swipt_pwm_gen
  import swipt_pkg::*;
#(
  parameter int PERIOD   = PERIOD_DEF,
  parameter int DEADTIME = DEADTIME_DEF
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               en,
  input  logic [L_WIDTH-1:0] l,
  output logic               pwm_h,
  output logic               pwm_l,
  output logic               period_start,
  output logic [L_WIDTH-1:0] l_active,
  output swipt_state_t       fsm_state
);

  localparam logic [L_WIDTH-1:0] PERIOD_L  = L_WIDTH'(PERIOD);
  localparam logic [L_WIDTH-1:0] PERIOD_M1 = L_WIDTH'(PERIOD - 1);

  logic [L_WIDTH-1:0] cnt;
  logic               en_d;
  logic               sample;
  logic               raw;

  // Load the shadow on the last count of a period, and on the first enabled
  // cycle so a fresh start does not run with a stale level. en_d is cleared
  // by reset, so the first enabled cycle after reset also counts as a start.
  assign sample = en && (!en_d || cnt == PERIOD_M1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt      <= '0;
      en_d     <= 1'b0;
      l_active <= '0;
    end else begin
      en_d <= en;
      if (!en) begin
        cnt <= '0;
      end else if (cnt == PERIOD_M1) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (sample) begin
        l_active <= clamp_level(l, PERIOD_L);
      end
    end
  end

  assign raw = (cnt < l_active);

  // Gated by nrst so the pulse is absent while reset is held even with en=1.
  assign period_start = nrst && en && (cnt == '0);

  swipt_deadtime #(
    .DEADTIME(DEADTIME)
  ) u_deadtime (
    .clk  (clk),
    .nrst (nrst),
    .en   (en),
    .raw  (raw),
    .pwm_h(pwm_h),
    .pwm_l(pwm_l),
    .state(fsm_state)
  );

endmodule

// File: tb/tb_swipt_pwm_gen.sv
// Directed bench for swipt_pwm_gen with PERIOD=500, DEADTIME=8.
module tb_swipt_pwm_gen;
  import swipt_pkg::*;

  localparam int PER = 500;

  // clock / reset
  logic         clk = 1'b0;
  logic         nrst;
  logic         en;
  logic [11:0]  l;
  logic         pwm_h;
  logic         pwm_l;
  logic         period_start;
  logic [11:0]  l_active;
  swipt_state_t fsm_state;

  always #5 clk = ~clk;

  swipt_pwm_gen #(
    .PERIOD  (PER),
    .DEADTIME(8)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .en          (en),
    .l           (l),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l),
    .period_start(period_start),
    .l_active    (l_active),
    .fsm_state   (fsm_state)
  );

  // scoreboard
  int          n_total = 0;
  int          n_bad   = 0;
  logic [11:0] exp_q[$];

  logic samp_h[PER];
  logic samp_l[PER];
  int   m_h, m_l, m_off, m_ov, m_ps;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge with period_start high (cnt==0), bounded.
  task automatic wait_ps(input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge clk);
      if (period_start) begin
        found = 1;
        break;
      end
    end
    check({tag, "_ps_seen"}, found, 1);
  endtask

  task automatic settle(input string tag);
    wait_ps(tag);
    wait_ps(tag);
  endtask

  // Sample one full period starting at the current negedge (cnt==0);
  // ends on the negedge of cnt==0 of the following period.
  task automatic measure(input string tag);
    m_h = 0; m_l = 0; m_off = 0; m_ov = 0; m_ps = 0;
    for (int i = 0; i < PER; i++) begin
      samp_h[i] = pwm_h;
      samp_l[i] = pwm_l;
      if (pwm_h) m_h++;
      if (pwm_l) m_l++;
      if (!pwm_h && !pwm_l) m_off++;
      if (pwm_h && pwm_l) m_ov++;
      if (period_start) m_ps++;
      @(negedge clk);
    end
    check({tag, "_overlap"}, m_ov, 0);
    check({tag, "_ps_count"}, m_ps, 1);
    check({tag, "_ps_next"}, int'(period_start), 1);
  endtask

  initial begin
    nrst = 1'b0;
    en   = 1'b1;
    l    = 12'd250;

    // reset state, with en high to show period_start stays low
    step(2);
    check("rst_pwm_h", int'(pwm_h), 0);
    check("rst_pwm_l", int'(pwm_l), 0);
    check("rst_ps", int'(period_start), 0);
    check("rst_l_active", int'(l_active), 0);
    check("rst_state", int'(fsm_state), int'(IDLE));

    en = 1'b0;
    step(1);
    nrst = 1'b1;
    step(1);
    check("idle_ps", int'(period_start), 0);
    check("idle_state", int'(fsm_state), int'(IDLE));
    check("idle_l_active", int'(l_active), 0);

    // first enabled cycle: cnt==0, level sampled, FSM enters DT
    en = 1'b1;
    #1;
    check("start_ps", int'(period_start), 1);
    step(1);
    check("start_state", int'(fsm_state), int'(DT));
    check("start_l_active", int'(l_active), 250);
    check("start_pwm_h", int'(pwm_h), 0);

    // l=250 steady: 242 high, 242 low, 16 dead
    settle("l250");
    measure("l250");
    check("l250_h", m_h, 242);
    check("l250_l", m_l, 242);
    check("l250_off", m_off, 16);
    check("l250_h_at8", int'(samp_h[8]), 0);
    check("l250_h_at9", int'(samp_h[9]), 1);
    check("l250_h_at250", int'(samp_h[250]), 1);
    check("l250_h_at251", int'(samp_h[251]), 0);
    check("l250_l_at258", int'(samp_l[258]), 0);
    check("l250_l_at259", int'(samp_l[259]), 1);
    check("l250_l_at0", int'(samp_l[0]), 1);

    // l=0: continuous low side
    l = 12'd0;
    settle("l0");
    measure("l0");
    check("l0_l_active", int'(l_active), 0);
    check("l0_h", m_h, 0);
    check("l0_l", m_l, 500);

    // l=600 clamps to 500: continuous high side
    l = 12'd600;
    settle("l600");
    check("l600_l_active", int'(l_active), 500);
    measure("l600");
    check("l600_h", m_h, 500);
    check("l600_l", m_l, 0);
    check("l600_off", m_off, 0);

    // l=5: high pulse swallowed, low resumes after 8 dead cycles
    l = 12'd5;
    settle("l5");
    measure("l5");
    check("l5_h", m_h, 0);
    check("l5_l", m_l, 492);
    check("l5_off", m_off, 8);
    check("l5_l_at0", int'(samp_l[0]), 1);
    check("l5_l_at8", int'(samp_l[8]), 0);
    check("l5_l_at9", int'(samp_l[9]), 1);

    // l changes 100->400 mid-period: current period unaffected
    l = 12'd100;
    settle("l100");
    check("l100_l_active", int'(l_active), 100);
    step(150);
    check("l100_pwm_l_at150", int'(pwm_l), 1);
    check("l100_pwm_h_at150", int'(pwm_h), 0);
    step(50);
    l = 12'd400;
    exp_q.push_back(12'd100);
    step(100);
    check("lchg_pwm_h_at300", int'(pwm_h), 0);
    check("lchg_l_active_at300", int'(l_active), int'(exp_q[0]));
    step(199);
    check("lchg_l_active_at499", int'(l_active), int'(exp_q.pop_front()));
    exp_q.push_back(12'd400);
    step(1);
    check("lchg_ps_wrap", int'(period_start), 1);
    check("lchg_l_active_wrap", int'(l_active), int'(exp_q.pop_front()));
    measure("l400");
    check("l400_h", m_h, 392);
    check("l400_l", m_l, 92);

    // asynchronous reset in the middle of H_ON
    step(100);
    check("arst_pre_h", int'(pwm_h), 1);
    #2;
    nrst = 1'b0;
    #1;
    check("arst_pwm_h", int'(pwm_h), 0);
    check("arst_pwm_l", int'(pwm_l), 0);
    check("arst_l_active", int'(l_active), 0);
    check("arst_state", int'(fsm_state), int'(IDLE));
    check("arst_ps", int'(period_start), 0);
    step(2);
    nrst = 1'b1;
    #1;
    check("arst_rel_ps", int'(period_start), 1);
    step(1);
    check("arst_rel_state", int'(fsm_state), int'(DT));
    check("arst_rel_l_active", int'(l_active), 400);
    step(7);
    check("arst_rel_h_at8", int'(pwm_h), 0);
    step(1);
    check("arst_rel_h_at9", int'(pwm_h), 1);

    // en dropped during H_ON
    step(50);
    check("endrop_pre_h", int'(pwm_h), 1);
    en = 1'b0;
    #1;
    check("endrop_ps", int'(period_start), 0);
    step(1);
    check("endrop_pwm_h", int'(pwm_h), 0);
    check("endrop_pwm_l", int'(pwm_l), 0);
    check("endrop_state", int'(fsm_state), int'(IDLE));
    en = 1'b1;
    #1;
    check("endrop_cnt0_ps", int'(period_start), 1);
    step(1);
    check("endrop_restart_state", int'(fsm_state), int'(DT));

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
